// File: rtl/dot_matrix_pkg.sv
// Shared constants, width helper and scan state type
// for the bicolour dot-matrix animator.
package dot_matrix_pkg;

    localparam int MODE_OFF  = 0;
    localparam int MODE_VENT = 1;
    localparam int MODE_WARM = 2;
    localparam int MODE_HOT  = 3;
    localparam int MODE_DRY  = 4;

    typedef enum logic {
        POR,
        RUN
    } state_e;

    // Counter width for a range of n values, never narrower than 1 bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dot_pattern_rom.sv
// Animation pattern store: synchronous read of one row of
// red/green column data addressed by {mode, frame, row}.
module dot_pattern_rom
    import dot_matrix_pkg::*;
#(
    parameter int N_ROWS   = 8,
    parameter int N_COLS   = 8,
    parameter int MODE_W   = 3,
    parameter int N_FRAMES = 4,
    localparam int RW = cw(N_ROWS),
    localparam int FW = cw(N_FRAMES),
    localparam int AW = MODE_W + FW + RW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     addr,
    output logic [N_COLS-1:0] red,
    output logic [N_COLS-1:0] grn
);

    logic [MODE_W-1:0] mode;
    logic [FW-1:0]     frame;
    logic [RW-1:0]     row;
    logic [N_COLS-1:0] red_d;
    logic [N_COLS-1:0] grn_d;
    int                phase;

    assign {mode, frame, row} = addr;

    // Patterns are generated from the address so they scale with N_COLS.
    always_comb begin
        red_d = '0;
        grn_d = '0;
        phase = (int'(row) + int'(frame)) % N_COLS;
        case (mode)
            MODE_W'(MODE_VENT): begin
                grn_d = N_COLS'(1) << phase;
            end
            MODE_W'(MODE_WARM): begin
                for (int c = 0; c < N_COLS; c++)
                    red_d[c] = c[0] ^ row[0] ^ frame[0];
            end
            MODE_W'(MODE_HOT): begin
                red_d = {N_COLS{~(row[0] ^ frame[0])}};
                grn_d = ~red_d;
            end
            MODE_W'(MODE_DRY): begin
                red_d = N_COLS'(1) << (N_COLS - 1 - phase);
                grn_d = red_d;
            end
            default: begin
                red_d = '0;
                grn_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red <= '0;
            grn <= '0;
        end else begin
            red <= red_d;
            grn <= grn_d;
        end
    end

endmodule

// File: rtl/dot_matrix_animator.sv
// Row-multiplexed bicolour LED matrix scanner with blanking,
// power-on lamp test, frame freeze and sweep-aligned mode switching.
module dot_matrix_animator
    import dot_matrix_pkg::*;
#(
    parameter int N_ROWS       = 8,
    parameter int N_COLS       = 8,
    parameter int MODE_W       = 3,
    parameter int N_MODES      = 5,
    parameter int N_FRAMES     = 4,
    parameter int ROW_DIV      = 1000,
    parameter int BLANK_CYC    = 8,
    parameter int FRAME_SWEEPS = 62,
    parameter int POR_SWEEPS   = 125,
    localparam int FW = cw(N_FRAMES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic              run,
    input  logic              lamp_test,
    output logic [N_ROWS-1:0] row_n,
    output logic [N_COLS-1:0] col_red,
    output logic [N_COLS-1:0] col_grn,
    output logic [FW-1:0]     frame_idx,
    output logic [MODE_W-1:0] mode_active,
    output logic              sweep_done
);

    localparam int RW  = cw(N_ROWS);
    localparam int SW  = cw(ROW_DIV);
    localparam int SCW = cw(FRAME_SWEEPS);
    localparam int PW  = cw(POR_SWEEPS);

    state_e            state;
    logic [SW-1:0]     slot_cnt;
    logic [SW-1:0]     nxt_slot;
    logic [RW-1:0]     row_cnt;
    logic [RW-1:0]     nxt_row;
    logic [SCW-1:0]    sweep_cnt;
    logic [PW-1:0]     por_cnt;
    logic [N_COLS-1:0] rom_red;
    logic [N_COLS-1:0] rom_grn;
    logic              slot_end;
    logic              sweep_end;
    logic              nxt_drive;
    logic              nxt_last;
    logic              mode_ok;

    dot_pattern_rom #(
        .N_ROWS   (N_ROWS),
        .N_COLS   (N_COLS),
        .MODE_W   (MODE_W),
        .N_FRAMES (N_FRAMES)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  ({mode_active, frame_idx, row_cnt}),
        .red   (rom_red),
        .grn   (rom_grn)
    );

    // Outputs are registered from the next counter values so that the
    // visible scan position lines up with the slot/row counters.
    always_comb begin
        slot_end  = slot_cnt == SW'(ROW_DIV - 1);
        sweep_end = slot_end && (row_cnt == RW'(N_ROWS - 1));
        nxt_slot  = slot_end ? '0 : slot_cnt + SW'(1);
        nxt_row   = row_cnt;
        if (slot_end)
            nxt_row = (row_cnt == RW'(N_ROWS - 1)) ? '0 : row_cnt + RW'(1);
        nxt_drive = nxt_slot >= SW'(BLANK_CYC);
        nxt_last  = (nxt_slot == SW'(ROW_DIV - 1))
                 && (nxt_row == RW'(N_ROWS - 1));
        mode_ok   = {1'b0, mode_sel} < (MODE_W + 1)'(N_MODES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= (POR_SWEEPS == 0) ? RUN : POR;
            slot_cnt    <= '0;
            row_cnt     <= '0;
            sweep_cnt   <= '0;
            por_cnt     <= '0;
            row_n       <= '1;
            col_red     <= '0;
            col_grn     <= '0;
            frame_idx   <= '0;
            mode_active <= '0;
            sweep_done  <= 1'b0;
        end else begin
            slot_cnt   <= nxt_slot;
            row_cnt    <= nxt_row;
            sweep_done <= nxt_last;
            row_n      <= nxt_drive ? ~(N_ROWS'(1) << nxt_row) : '1;

            if (!nxt_drive) begin
                col_red <= '0;
                col_grn <= '0;
            end else if (state == POR || lamp_test) begin
                col_red <= '1;
                col_grn <= '1;
            end else if (mode_active == MODE_W'(MODE_OFF)) begin
                col_red <= '0;
                col_grn <= '0;
            end else begin
                col_red <= rom_red;
                col_grn <= rom_grn;
            end

            // Mode and frame only move between sweeps, so a frame is
            // never drawn half old, half new.
            if (sweep_end) begin
                unique case (state)
                    POR: begin
                        if (por_cnt == PW'(POR_SWEEPS - 1)) begin
                            state       <= RUN;
                            mode_active <= '0;
                            frame_idx   <= '0;
                            sweep_cnt   <= '0;
                        end else begin
                            por_cnt <= por_cnt + PW'(1);
                        end
                    end
                    RUN: begin
                        if (mode_ok && mode_sel != mode_active) begin
                            mode_active <= mode_sel;
                            frame_idx   <= '0;
                            sweep_cnt   <= '0;
                        end else if (run) begin
                            if (sweep_cnt == SCW'(FRAME_SWEEPS - 1)) begin
                                sweep_cnt <= '0;
                                frame_idx <= (frame_idx == FW'(N_FRAMES - 1))
                                           ? '0 : frame_idx + FW'(1);
                            end else begin
                                sweep_cnt <= sweep_cnt + SCW'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dot_matrix_animator.md
Name: dot_matrix_animator

Overview:
Parametrised successor to the bathroom-heater dot-matrix animation driver. It produces the multiplexed red/green column drive and active-low row select for an N_ROWS x N_COLS bicolour LED matrix from a single clock. Animation frames come from a pattern ROM sub-module, indexed by mode, frame and row. Added over the previous generation:
- internal row/frame prescalers
- anti-ghost row blanking
- power-on lamp test
- run/pause frame freeze
- tear-free mode switching at sweep boundaries

Parameters:
N_ROWS, 8, matrix rows (scan lines)
N_COLS, 8, matrix columns per colour
MODE_W, 3, width of mode code
N_MODES, 5, valid modes 0..N_MODES-1; 0 = off (blank)
N_FRAMES, 4, animation frames per mode
ROW_DIV, 1000, clk cycles per row slot (1 MHz clk -> 1 kHz rows)
BLANK_CYC, 8, leading blank cycles per row slot; legal range 2..ROW_DIV-1
FRAME_SWEEPS, 62, full sweeps per animation frame (~0.5 s)
POR_SWEEPS, 125, all-on lamp-test sweeps after reset; 0 = skip

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
mode_sel  in  MODE_W  requested mode; values >= N_MODES ignored (hold current)
run  in  1  1 = advance frames; 0 = freeze current frame (scan continues)
lamp_test  in  1  level: all columns of both colours on while high
row_n  out  N_ROWS  row select, active low, at most one bit low
col_red  out  N_COLS  red column drive, active high
col_grn  out  N_COLS  green column drive, active high
frame_idx  out  clog2(N_FRAMES)  current animation frame
mode_active  out  MODE_W  mode currently displayed
sweep_done  out  1  one-cycle pulse on the last cycle of each full sweep

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - row_n all 1; col_red, col_grn 0; frame_idx 0; mode_active 0; sweep_done 0
  - all counters 0; state POR (or RUN if POR_SWEEPS = 0)
- Slot timing: slot counter 0..ROW_DIV-1 wraps. At wrap, row counter advances 0..N_ROWS-1 and wraps. A sweep is N_ROWS slots.
- Within a slot starting at cycle t:
  - t..t+BLANK_CYC-1: row_n all 1, columns 0
  - ROM is addressed at t; data is registered at t+1 (1-cycle latency, hence BLANK_CYC >= 2)
  - t+BLANK_CYC..t+ROW_DIV-1: row_n = ~(1 << row), columns = pattern
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - POR: columns all 1 during the drive window, for POR_SWEEPS sweeps. Inputs are ignored. Then go to RUN with mode_active 0, frame_idx 0.
  - RUN: normal animation.
- Column source priority (drive window only): lamp_test=1 -> all 1; else mode_active=0 -> all 0 (rows still scan); else ROM[mode_active][frame_idx][row].
- Sweep end (last cycle of slot N_ROWS-1): sweep_done=1. Then, in RUN:
  - If mode_sel is valid and != mode_active: mode_active <= mode_sel, frame_idx <= 0, sweep counter <= 0. Mode change takes priority over frame advance.
  - Else if run=1: sweep counter +1. When it reaches FRAME_SWEEPS-1, it clears and frame_idx advances, wrapping N_FRAMES-1 -> 0.
  - Else (run=0): sweep counter and frame_idx are held.
- mode_sel is sampled only at sweep end; changes mid-sweep have no effect until then (no tearing).
- Invalid mode_sel: mode_active unchanged, animation continues.
- lamp_test does not affect counters or frame advance.

Decomposition:
- Package dot_matrix_pkg:
  - mode code constants (MODE_OFF=0, MODE_VENT=1, MODE_WARM=2, MODE_HOT=3, MODE_DRY=4)
  - width helpers (clog2 of N_ROWS, N_FRAMES, ROW_DIV, FRAME_SWEEPS)
  - state enum {POR, RUN}
- Sub-module dot_pattern_rom:
  - synchronous read, address {mode, frame, row}, outputs {red, grn}
  - pattern contents live there, so the scan/timing core stays pattern-agnostic

Test Plan:
Bench params: N_ROWS=4, N_COLS=8, ROW_DIV=6, BLANK_CYC=2, FRAME_SWEEPS=2, POR_SWEEPS=1, N_FRAMES=4 (sweep = 24 cycles).
- Reset release -> first 24 cycles: row_n cycles 1110,1101,1011,0111 for 4 cycles each after 2 blank cycles, cols 0xFF both colours; sweep_done pulses at cycle 23; then mode_active=0, cols 0.
- mode_sel=1, run=1 applied mid-sweep -> mode_active stays 0 until sweep end, then becomes 1 with frame_idx=0; frame_idx steps 0,1,2,3,0 every 48 cycles; cols match ROM[1][f][row] only in drive window.
- run=0 while at frame_idx=2 for 5 sweeps -> frame_idx stays 2, row scan and sweep_done continue; run=1 -> next advance after 2 further sweeps.
- mode_sel=7 (invalid) while at mode 2 -> mode_active stays 2, animation continues; mode_sel=0 -> at sweep end cols 0, rows still scan.
- lamp_test=1 for 10 cycles in mode 3 -> cols 0xFF in drive windows only, blank windows still 0; frame_idx progression unaffected.
- rst_n low mid-drive window -> same-cycle row_n=1111, cols 0, frame_idx 0; POR lamp test repeats after release.
